// File: rtl/dmidebug_pkg.sv
// Shared types for the JTAG debug transport: TAP states, IR codes,
// DMI op/status codes and the DTM register bundle.
package dmidebug_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1f;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMISTAT_OK     = 2'd0;
  localparam logic [1:0] DMISTAT_FAILED = 2'd2;
  localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

  typedef struct packed {
    logic [1:0]  dmistat;
    logic        busy;
    logic        req_valid;
    logic        write;
    logic        hardreset;
    logic        tdo;
    logic [31:0] resp_data;
    logic [31:0] wdata;
  } dmi_jtag_dtm_registers;

  localparam dmi_jtag_dtm_registers DTM_REGS_RESET = '0;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller stepped by a synchronized TCK rising edge.
// Capture/shift strobes fire while in the state, update on entry.
module jtag_tap_fsm
  import dmidebug_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tck_rise,
  input  logic       tms,
  output tap_state_e state,
  output logic       tlr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TAP_TLR;
    end else if (tck_rise) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:      state_d = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      state_d = TAP_TLR;
    endcase
  end

  assign state      = state_q;
  assign tlr        = tck_rise && (state_d == TAP_TLR);
  assign capture_ir = tck_rise && (state_q == TAP_CAP_IR);
  assign shift_ir   = tck_rise && (state_q == TAP_SHIFT_IR);
  assign update_ir  = tck_rise && (state_d == TAP_UPD_IR);
  assign capture_dr = tck_rise && (state_q == TAP_CAP_DR);
  assign shift_dr   = tck_rise && (state_q == TAP_SHIFT_DR);
  assign update_dr  = tck_rise && (state_d == TAP_UPD_DR);

endmodule

// File: rtl/dmi_jtag_dtm.sv
// JTAG DTM oversampled in the system clock domain; turns DMI scans
// into single-entry debug module requests with busy/sticky status.
module dmi_jtag_dtm
  import dmidebug_pkg::*;
#(
  parameter int          abits  = 7,
  parameter int          irlen  = 5,
  parameter logic [31:0] idcode = 32'h10e31913
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tck,
  input  logic             i_tms,
  input  logic             i_tdi,
  output logic             o_tdo,
  output logic             o_dmi_req_valid,
  input  logic             i_dmi_req_ready,
  output logic             o_dmi_write,
  output logic [abits-1:0] o_dmi_addr,
  output logic [31:0]      o_dmi_wdata,
  input  logic             i_dmi_resp_valid,
  input  logic [31:0]      i_dmi_resp_data,
  output logic             o_dmi_hardreset
);

  localparam int DRW = abits + 34;

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;
  logic       tck_rise;
  logic       tck_fall;
  logic       tms;
  logic       tdi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
    end else begin
      tck_q <= {tck_q[1:0], i_tck};
      tms_q <= {tms_q[0], i_tms};
      tdi_q <= {tdi_q[0], i_tdi};
    end
  end

  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms      = tms_q[1];
  assign tdi      = tdi_q[1];

  tap_state_e tap_state;
  logic tlr;
  logic capture_ir;
  logic shift_ir;
  logic update_ir;
  logic capture_dr;
  logic shift_dr;
  logic update_dr;

  jtag_tap_fsm u_tap (
    .clk        (i_clk),
    .rst        (i_rst),
    .tck_rise   (tck_rise),
    .tms        (tms),
    .state      (tap_state),
    .tlr        (tlr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr)
  );

  dmi_jtag_dtm_registers r;
  dmi_jtag_dtm_registers r_d;
  logic [irlen-1:0] ir;
  logic [irlen-1:0] ir_d;
  logic [irlen-1:0] ir_sr;
  logic [irlen-1:0] ir_sr_d;
  logic [DRW-1:0]   dr_sr;
  logic [DRW-1:0]   dr_d;
  logic [abits-1:0] addr;
  logic [abits-1:0] addr_d;

  logic sel_idcode;
  logic sel_dtmcs;
  logic sel_dmi;
  logic sel_bypass;

  assign sel_idcode = (ir == irlen'(IR_IDCODE));
  assign sel_dtmcs  = (ir == irlen'(IR_DTMCS));
  assign sel_dmi    = (ir == irlen'(IR_DMI));
  assign sel_bypass = ~(sel_idcode | sel_dtmcs | sel_dmi);

  logic        resp_take;
  logic        busy_now;
  logic [31:0] resp_now;
  logic [1:0]  op;

  // A response in the same cycle as a capture is applied first.
  assign resp_take = i_dmi_resp_valid & r.busy;
  assign busy_now  = r.busy & ~i_dmi_resp_valid;
  assign resp_now  = resp_take ? i_dmi_resp_data : r.resp_data;
  assign op        = dr_sr[1:0];

  always_comb begin
    r_d     = r;
    ir_d    = ir;
    ir_sr_d = ir_sr;
    dr_d    = dr_sr;
    addr_d  = addr;
    r_d.hardreset = 1'b0;

    if (r.req_valid && i_dmi_req_ready) begin
      r_d.req_valid = 1'b0;
    end
    if (resp_take) begin
      r_d.busy      = 1'b0;
      r_d.resp_data = i_dmi_resp_data;
    end
    if (tck_fall) begin
      r_d.tdo = (tap_state == TAP_SHIFT_IR) ? ir_sr[0] : dr_sr[0];
    end

    if (tlr) ir_d = irlen'(IR_IDCODE);
    if (capture_ir) ir_sr_d = irlen'(1);
    if (shift_ir) ir_sr_d = {tdi, ir_sr[irlen-1:1]};
    if (update_ir) ir_d = ir_sr;

    if (capture_dr) begin
      unique case (1'b1)
        sel_idcode: dr_d[31:0] = idcode;
        sel_dtmcs:
          dr_d[31:0] = {17'd0, 3'd1, r.dmistat, 6'(abits), 4'd1};
        sel_dmi: begin
          if (busy_now) begin
            r_d.dmistat = DMISTAT_BUSY;
            dr_d = {addr, resp_now, DMISTAT_BUSY};
          end else begin
            dr_d = {addr, resp_now, r.dmistat};
          end
        end
        sel_bypass: dr_d[0] = 1'b0;
        default: ;
      endcase
    end

    if (shift_dr) begin
      unique case (1'b1)
        sel_dmi:    dr_d = {tdi, dr_sr[DRW-1:1]};
        sel_bypass: dr_d[0] = tdi;
        default:    dr_d[31:0] = {tdi, dr_sr[31:1]};
      endcase
    end

    if (update_dr && sel_dtmcs) begin
      if (dr_sr[16]) r_d.dmistat = DMISTAT_OK;
      // Hardreset overrides a same-cycle ready and any pending request.
      if (dr_sr[17]) begin
        r_d.dmistat   = DMISTAT_OK;
        r_d.busy      = 1'b0;
        r_d.req_valid = 1'b0;
        r_d.hardreset = 1'b1;
      end
    end else if (update_dr && sel_dmi && r.dmistat == DMISTAT_OK) begin
      if (busy_now) begin
        r_d.dmistat = DMISTAT_BUSY;
      end else if (op == DMI_OP_READ) begin
        addr_d        = dr_sr[DRW-1:34];
        r_d.write     = 1'b0;
        r_d.busy      = 1'b1;
        r_d.req_valid = 1'b1;
      end else if (op == DMI_OP_WRITE) begin
        addr_d        = dr_sr[DRW-1:34];
        r_d.wdata     = dr_sr[33:2];
        r_d.write     = 1'b1;
        r_d.busy      = 1'b1;
        r_d.req_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r     <= DTM_REGS_RESET;
      ir    <= irlen'(IR_IDCODE);
      ir_sr <= '0;
      dr_sr <= '0;
      addr  <= '0;
    end else begin
      r     <= r_d;
      ir    <= ir_d;
      ir_sr <= ir_sr_d;
      dr_sr <= dr_d;
      addr  <= addr_d;
    end
  end

  assign o_tdo           = r.tdo;
  assign o_dmi_req_valid = r.req_valid;
  assign o_dmi_write     = r.write;
  assign o_dmi_addr      = addr;
  assign o_dmi_wdata     = r.wdata;
  assign o_dmi_hardreset = r.hardreset;

endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// Randomized bench for dmi_jtag_dtm: bit-banged JTAG scans checked
// against a transaction-level model of the DTM/DMI status rules.
module tb_dmi_jtag_dtm;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_tck;
  logic        i_tms;
  logic        i_tdi;
  logic        o_tdo;
  logic        o_dmi_req_valid;
  logic        i_dmi_req_ready;
  logic        o_dmi_write;
  logic [6:0]  o_dmi_addr;
  logic [31:0] o_dmi_wdata;
  logic        i_dmi_resp_valid;
  logic [31:0] i_dmi_resp_data;
  logic        o_dmi_hardreset;

  always #5 clk = ~clk;

  dmi_jtag_dtm dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_tck            (i_tck),
    .i_tms            (i_tms),
    .i_tdi            (i_tdi),
    .o_tdo            (o_tdo),
    .o_dmi_req_valid  (o_dmi_req_valid),
    .i_dmi_req_ready  (i_dmi_req_ready),
    .o_dmi_write      (o_dmi_write),
    .o_dmi_addr       (o_dmi_addr),
    .o_dmi_wdata      (o_dmi_wdata),
    .i_dmi_resp_valid (i_dmi_resp_valid),
    .i_dmi_resp_data  (i_dmi_resp_data),
    .o_dmi_hardreset  (o_dmi_hardreset)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int hr_cnt  = 0;

  always @(posedge clk) if (o_dmi_hardreset === 1'b1) hr_cnt <= hr_cnt + 1;

  // Reference model state
  logic [1:0]  m_stat;
  logic        m_busy;
  logic        m_pending;
  logic [6:0]  m_addr;
  logic [31:0] m_resp;
  logic [31:0] m_wdata;
  logic        m_write;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tck_cycle(input logic tms, input logic tdi,
                           output logic tdo);
    i_tck = 1'b0;
    i_tms = tms;
    i_tdi = tdi;
    repeat (4) @(negedge clk);
    tdo = o_tdo;
    i_tck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic ir_scan(input logic [4:0] code);
    logic b;
    logic [4:0] cap;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, code[i], b);
      cap[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    check("ir_capture", 64'(cap), 64'h1);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din,
                         output logic [63:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic check_req();
    check("req_valid", 64'(o_dmi_req_valid), 64'(m_pending));
    check("req_addr", 64'(o_dmi_addr), 64'(m_addr));
    check("req_write", 64'(o_dmi_write), 64'(m_write));
    check("req_wdata", 64'(o_dmi_wdata), 64'(m_wdata));
  endtask

  task automatic dmi_op(input logic [1:0] op, input logic [6:0] a,
                        input logic [31:0] d);
    logic [63:0] got;
    logic [63:0] exp;
    ir_scan(5'h11);
    exp = {23'd0, m_addr, m_resp, (m_busy ? 2'd3 : m_stat)};
    if (m_busy) m_stat = 2'd3;
    dr_scan(41, {23'd0, a, d, op}, got);
    check("dmi_capture", got, exp);
    if (m_stat == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
      m_busy    = 1'b1;
      m_pending = 1'b1;
      m_addr    = a;
      m_write   = (op == 2'd2);
      if (op == 2'd2) m_wdata = d;
    end
    check_req();
  endtask

  task automatic dtmcs_op(input logic [31:0] val);
    logic [63:0] got;
    int hr0;
    ir_scan(5'h10);
    hr0 = hr_cnt;
    dr_scan(32, 64'(val), got);
    check("dtmcs_capture", got, {32'd0, 17'd0, 3'd1, m_stat, 6'd7, 4'd1});
    if (val[17]) begin
      m_stat = 2'd0;
      m_busy = 1'b0;
      m_pending = 1'b0;
    end else if (val[16]) begin
      m_stat = 2'd0;
    end
    check("hardreset_pulses", 64'(hr_cnt - hr0), 64'(val[17]));
    check("valid_after_dtmcs", 64'(o_dmi_req_valid), 64'(m_pending));
  endtask

  task automatic accept(input int wait_n);
    repeat (wait_n) @(negedge clk);
    check("valid_hold", 64'(o_dmi_req_valid), 64'(1));
    i_dmi_req_ready = 1'b1;
    @(negedge clk);
    i_dmi_req_ready = 1'b0;
    m_pending = 1'b0;
    check("valid_drop", 64'(o_dmi_req_valid), 64'(0));
  endtask

  task automatic respond(input logic [31:0] d);
    i_dmi_resp_valid = 1'b1;
    i_dmi_resp_data  = d;
    @(negedge clk);
    i_dmi_resp_valid = 1'b0;
    i_dmi_resp_data  = '0;
    if (m_busy) begin
      m_busy = 1'b0;
      m_resp = d;
    end
  endtask

  initial begin
    logic [63:0] got;
    logic [7:0]  byp;
    logic        b;
    i_rst = 1'b1;
    i_tck = 1'b0;
    i_tms = 1'b0;
    i_tdi = 1'b0;
    i_dmi_req_ready  = 1'b0;
    i_dmi_resp_valid = 1'b0;
    i_dmi_resp_data  = '0;
    m_stat = '0; m_busy = 0; m_pending = 0;
    m_addr = '0; m_resp = '0; m_wdata = '0; m_write = 0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_tdo", 64'(o_tdo), 64'(0));
    check("rst_hardreset", 64'(o_dmi_hardreset), 64'(0));
    check_req();

    tck_cycle(1'b0, 1'b0, b);
    dr_scan(32, 64'd0, got);
    check("idcode_rst", got, 64'h10e31913);

    dtmcs_op(32'd0);

    ir_scan(5'h1f);
    byp = 8'($urandom);
    dr_scan(8, 64'(byp), got);
    check("bypass", got, 64'({byp[6:0], 1'b0}));

    dmi_op(2'd2, 7'h10, 32'h1);
    accept(3);
    respond(32'h0);
    dmi_op(2'd1, 7'h11, 32'h0);
    accept(0);
    respond(32'hdeadbeef);
    dmi_op(2'd0, 7'h00, 32'h0);

    // Busy path: request accepted but response withheld
    dmi_op(2'd1, 7'h05, 32'h0);
    accept(1);
    dmi_op(2'd2, 7'h22, 32'h1234);
    dtmcs_op(32'h0001_0000);
    respond(32'h5a5a5a5a);
    dmi_op(2'd0, 7'h00, 32'h0);

    // Hardreset with ready held low
    dmi_op(2'd2, 7'h33, 32'hcafef00d);
    dtmcs_op(32'h0002_0000);
    respond(32'h1111_2222);
    dmi_op(2'd0, 7'h00, 32'h0);

    for (int it = 0; it < 20; it++) begin
      if (m_busy) begin
        case ($urandom_range(2))
          0: begin
            if (m_pending) accept($urandom_range(3));
            respond($urandom);
          end
          1: dtmcs_op(32'h0002_0000);
          default: ;
        endcase
      end else if ($urandom_range(3) == 0) begin
        respond($urandom);
      end
      if (m_stat != 2'd0 && $urandom_range(3) != 0) begin
        dtmcs_op(32'h0001_0000);
      end
      dmi_op(2'($urandom), 7'($urandom), $urandom);
      if (m_pending && $urandom_range(2) != 0) begin
        accept($urandom_range(4));
        if ($urandom_range(1) == 1) respond($urandom);
      end
    end

    ir_scan(5'h11);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    dr_scan(32, 64'd0, got);
    check("idcode_tlr", got, 64'h10e31913);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
